red_serial: RTL and testbench

//  Area-reduced, multi-cycle RED (byte-pair reduction) execution unit.

---
 rtl/red_serial_pkg.sv | 20 ++
 rtl/red_serial_if.sv | 24 ++
 rtl/red_serial_add4_slice.sv | 14 +
 rtl/red_serial.sv | 156 +++++++++++++++
 tb/tb_red_serial.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/red_serial_pkg.sv
// red_pkg: shared types and constants for the serial RED execution unit.
//   state_t : FSM state encoding (4 bits). Any value not listed decodes to IDLE.
//   RED_LAT : number of clock edges from accept to out_valid.
package red_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    HI0  = 4'd1,
    HI1  = 4'd2,
    LO0  = 4'd3,
    LO1  = 4'd4,
    F0   = 4'd5,
    F1   = 4'd6,
    F2   = 4'd7,
    DONE = 4'd8
  } state_t;

  localparam int unsigned RED_LAT = 7;

endpackage

// File: rtl/red_serial_if.sv
// red_serial_if: issue-side and writeback-side handshake bundle for red_serial.
//   in_valid/in_ready/a/b     : operand handshake (master -> unit)
//   out_valid/out_ready/sum   : result handshake (unit -> master)
//   busy                      : unit is not idle
interface red_serial_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, busy
  );
endinterface

// File: rtl/red_serial_add4_slice.sv
// add4_slice: 4-bit ripple adder slice, purely combinational.
//   a_i, b_i : 4-bit addends
//   cin_i    : carry in
//   sum_o    : 4-bit sum
//   cout_o   : carry out
module add4_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
endmodule

// File: rtl/red_serial.sv
// red_serial: multi-cycle RED (byte-pair reduction) unit built around one
// shared 4-bit adder slice. Result appears RED_LAT edges after accept.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous abort, returns to IDLE and drives sum to RESET_SUM
//   bus        : red_serial_if.slave (operand/result handshakes, sum, busy)
module red_serial
  import red_pkg::*;
#(
  parameter logic [15:0] RESET_SUM = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  red_serial_if.slave        bus
);

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [8:0]  ac_q, ac_d, bd_q, bd_d;
  logic        c_q, c_d;
  logic [15:0] sum_q, sum_d;

  logic [3:0]  slice_a, slice_b, slice_sum;
  logic        slice_cin, slice_cout;
  logic        in_ready_w, accept;

  add4_slice u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (slice_cin),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  assign in_ready_w    = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept        = bus.in_valid & in_ready_w & ~flush;
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    ac_d      = ac_q;
    bd_d      = bd_q;
    c_d       = c_q;
    sum_d     = sum_q;
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HI0;
          a_d     = bus.a;
          b_d     = bus.b;
        end
      end
      HI0: begin
        slice_a   = a_q[11:8];
        slice_b   = b_q[11:8];
        ac_d[3:0] = slice_sum;
        c_d       = slice_cout;
        state_d   = HI1;
      end
      HI1: begin
        slice_a   = a_q[15:12];
        slice_b   = b_q[15:12];
        slice_cin = c_q;
        ac_d[7:4] = slice_sum;
        ac_d[8]   = slice_cout;
        state_d   = LO0;
      end
      LO0: begin
        slice_a   = a_q[3:0];
        slice_b   = b_q[3:0];
        bd_d[3:0] = slice_sum;
        c_d       = slice_cout;
        state_d   = LO1;
      end
      LO1: begin
        slice_a   = a_q[7:4];
        slice_b   = b_q[7:4];
        slice_cin = c_q;
        bd_d[7:4] = slice_sum;
        bd_d[8]   = slice_cout;
        state_d   = F0;
      end
      F0: begin
        slice_a    = ac_q[3:0];
        slice_b    = bd_q[3:0];
        sum_d[3:0] = slice_sum;
        c_d        = slice_cout;
        state_d    = F1;
      end
      F1: begin
        slice_a    = ac_q[7:4];
        slice_b    = bd_q[7:4];
        slice_cin  = c_q;
        sum_d[7:4] = slice_sum;
        c_d        = slice_cout;
        state_d    = F2;
      end
      F2: begin
        // byte carries sign-extend into the top nibble; final carry is dropped
        slice_a      = {4{ac_q[8]}};
        slice_b      = {4{bd_q[8]}};
        slice_cin    = c_q;
        sum_d[11:8]  = slice_sum;
        sum_d[15:12] = {4{slice_sum[3]}};
        state_d      = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          if (accept) begin
            state_d = HI0;
            a_d     = bus.a;
            b_d     = bus.b;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      sum_d   = RESET_SUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ac_q    <= '0;
      bd_q    <= '0;
      c_q     <= 1'b0;
      sum_q   <= RESET_SUM;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ac_q    <= ac_d;
      bd_q    <= bd_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_red_serial.sv
module tb_red_serial;
  import red_pkg::*;

  localparam logic [15:0] RST_SUM = 16'hDEAD;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   failures;

  red_serial_if bus ();

  red_serial #(.RESET_SUM(RST_SUM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_sum;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // advance until out_valid, bounded; returns number of edges taken
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic run_vec(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_sum);
    int n;
    int busy_cnt;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    chk({name, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    busy_cnt = int'(bus.busy);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
      busy_cnt += int'(bus.busy);
    end
    chk({name, ".latency"}, 32'(n), 32'(RED_LAT));
    chk({name, ".sum"}, 32'(bus.sum), 32'(exp_sum));
    chk({name, ".busy_cycles"}, 32'(busy_cnt), 32'(RED_LAT + 1));
    step();
    chk({name, ".out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({name, ".sum_hold"}, 32'(bus.sum), 32'(exp_sum));
  endtask

  initial begin
    int n;
    int xfers;
    logic [15:0] held;

    checks   = 0;
    failures = 0;

    vecs[0] = '{16'h0101, 16'h0101, 16'h0004};
    vecs[1] = '{16'h1234, 16'h4321, 16'h00AA};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFC};
    vecs[3] = '{16'h8000, 16'h8000, 16'hFF00};
    vecs[4] = '{16'h00FF, 16'h0001, 16'hFF00};
    vecs[5] = '{16'h007F, 16'h0001, 16'h0080};
    vecs[6] = '{16'h7F00, 16'h0100, 16'h0080};
    vecs[7] = '{16'h1280, 16'h0080, 16'hFF12};

    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    #22;
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.sum", 32'(bus.sum), 32'(RST_SUM));
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_sum);
    end

    // back-to-back: second op accepted in the first op's DONE cycle
    bus.a = 16'h1234; bus.b = 16'h4321;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    wait_valid(n);
    chk("b2b.lat1", 32'(n), 32'(RED_LAT));
    chk("b2b.sum1", 32'(bus.sum), 32'h00AA);
    chk("b2b.in_ready_done", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("b2b.busy_after", 32'(bus.busy), 32'd1);
    chk("b2b.ov_after", 32'(bus.out_valid), 32'd0);
    wait_valid(n);
    chk("b2b.lat2", 32'(n + 1), 32'(RED_LAT + 1));
    chk("b2b.sum2", 32'(bus.sum), 32'hFFFC);
    step();
    chk("b2b.idle", 32'(bus.busy), 32'd0);

    // stall in DONE with a pending op offered
    bus.a = 16'h8000; bus.b = 16'h8000;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step();
    bus.a = 16'h0101; bus.b = 16'h0101;
    wait_valid(n);
    chk("stall.lat", 32'(n), 32'(RED_LAT));
    held = bus.sum;
    chk("stall.sum", 32'(held), 32'hFF00);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall.ov%0d", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stall.sum%0d", k), 32'(bus.sum), 32'(held));
      chk($sformatf("stall.ir%0d", k), 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    xfers = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid && bus.out_ready) xfers++;
      step();
    end
    chk("stall.one_xfer", 32'(xfers), 32'd1);
    chk("stall.idle", 32'(bus.busy), 32'd0);

    // flush while in HI1; operands offered in the flush cycle are ignored
    bus.a = 16'h1234; bus.b = 16'h4321; bus.in_valid = 1'b1;
    step();
    bus.a = 16'h0101; bus.b = 16'h0101;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush.busy", 32'(bus.busy), 32'd0);
    chk("flush.ov", 32'(bus.out_valid), 32'd0);
    chk("flush.sum", 32'(bus.sum), 32'(RST_SUM));
    xfers = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid) xfers++;
      step();
    end
    chk("flush.no_result", 32'(xfers), 32'd0);

    // prime a non-reset sum, then reset asynchronously while in F1
    run_vec("pre_rst", 16'h1234, 16'h4321, 16'h00AA);
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.ov", 32'(bus.out_valid), 32'd0);
    chk("rst.sum", 32'(bus.sum), 32'(RST_SUM));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    xfers = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid) xfers++;
      step();
    end
    chk("rst.no_result", 32'(xfers), 32'd0);
    run_vec("post", 16'h0101, 16'h0101, 16'h0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
